muldiv_unit: RTL

Iterative RV32M multiply/divide execution unit with its own sequencing FSM. It sits beside the ALU in the execute stage and takes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU when the decoder routes funct7=0000001 here instead of to ALU_Control_Unit. It holds the pipeline via `busy` for a fixed multi-cycle latency and returns one 32-bit result with a `done` pulse.

---
 rtl/muldiv_unit_pkg.sv | 45 ++++
 rtl/muldiv_step.sv | 40 ++++
 rtl/muldiv_unit.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg
// Shared definitions for the RV32M multiply/divide unit:
//   - funct7 value that routes an instruction to this unit
//   - funct3 operation codes MULDIV_MUL .. MULDIV_REMU
//   - FSM state encoding and datapath step mode
//   - helpers that decode operand signed-ness from funct3
// Optional feature macro used by muldiv_unit: MULDIV_EARLY_OUT_EN.
package muldiv_unit_pkg;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] MULDIV_MUL    = 3'b000;
    localparam logic [2:0] MULDIV_MULH   = 3'b001;
    localparam logic [2:0] MULDIV_MULHSU = 3'b010;
    localparam logic [2:0] MULDIV_MULHU  = 3'b011;
    localparam logic [2:0] MULDIV_DIV    = 3'b100;
    localparam logic [2:0] MULDIV_DIVU   = 3'b101;
    localparam logic [2:0] MULDIV_REM    = 3'b110;
    localparam logic [2:0] MULDIV_REMU   = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_CALC = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } muldiv_state_e;

    typedef enum logic {
        STEP_MUL = 1'b0,
        STEP_DIV = 1'b1
    } step_mode_e;

    // rs1 is signed for MULH, MULHSU, DIV and REM.
    function automatic logic op_signed_a(input logic [2:0] f);
        return (f == MULDIV_MULH) || (f == MULDIV_MULHSU) ||
               (f == MULDIV_DIV)  || (f == MULDIV_REM);
    endfunction

    // rs2 is signed for MULH, DIV and REM (MULHSU treats it as unsigned).
    function automatic logic op_signed_b(input logic [2:0] f);
        return (f == MULDIV_MULH) || (f == MULDIV_DIV) || (f == MULDIV_REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step
// Combinational single-iteration datapath of the iterative multiplier/divider.
// Ports:
//   mode   : STEP_MUL (shift-add) or STEP_DIV (restoring subtract)
//   acc_i  : current 64-bit accumulator
//   opnd_i : multiplicand (multiply) or divisor (divide), magnitude only
//   acc_o  : accumulator after one iteration
// Multiply layout: acc = {partial product high, multiplier / product low}.
// Divide layout:   acc = {partial remainder, dividend / quotient bits}.
module muldiv_step
    import muldiv_unit_pkg::*;
(
    input  step_mode_e  mode,
    input  logic [63:0] acc_i,
    input  logic [31:0] opnd_i,
    output logic [63:0] acc_o
);

    logic [32:0] sum;
    logic [32:0] diff;

    always_comb begin
        // 33-bit add keeps the carry, which becomes the new top bit after the shift.
        sum  = {1'b0, acc_i[63:32]} + (acc_i[0] ? {1'b0, opnd_i} : 33'd0);
        // Shifted-in remainder is below 2*divisor, so the 33-bit difference
        // always fits and its MSB is a reliable sign.
        diff = {acc_i[63:32], acc_i[31]} - {1'b0, opnd_i};

        if (mode == STEP_DIV) begin
            if (!diff[32]) begin
                acc_o = {diff[31:0], acc_i[30:0], 1'b1};
            end else begin
                acc_o = {acc_i[62:0], 1'b0};
            end
        end else begin
            acc_o = {sum, acc_i[31:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit
// Iterative RV32M multiply/divide unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU)
// with a fixed 35-cycle latency from the accepting edge to the done pulse.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : issue request, accepted only in IDLE while kill is low
//   funct3            : operation select (inst[14:12])
//   op_a, op_b        : rs1 / rs2 values, latched when start is accepted
//   kill              : pipeline flush, aborts any operation in flight
//   busy              : high in PREP, CALC and FIX
//   done              : one-cycle pulse in DONE, result valid
//   result            : final value, held until the next done
// Optional feature macro: MULDIV_EARLY_OUT_EN. When defined, divide-by-zero,
// signed overflow and multiply-by-zero finish straight from PREP.
//
// Handshake: start is a request qualified by the unit being in IDLE (busy low,
// done low); it is never queued. busy stays high until the result is ready,
// then done pulses for exactly one cycle with result valid. A kill while busy
// drops the operation: no done, result untouched.
module muldiv_unit
    import muldiv_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        kill,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    muldiv_state_e state_q, state_d;
    logic [2:0]    funct3_q, funct3_d;
    logic [31:0]   a_q, a_d;
    logic [31:0]   b_q, b_d;
    logic [31:0]   opnd_q, opnd_d;
    logic [63:0]   acc_q, acc_d;
    logic [4:0]    cnt_q, cnt_d;
    logic          neg_q, neg_d;
    logic [31:0]   result_q, result_d;

    logic          is_div;
    logic          sign_a, sign_b;
    logic [31:0]   abs_a, abs_b;
    logic          div_by_zero, div_ovf;
    logic [31:0]   special_val;
    logic [63:0]   prod_signed;
    logic [31:0]   fix_val;
    logic [63:0]   acc_step;
    step_mode_e    step_mode;

    assign is_div    = funct3_q[2];
    assign step_mode = is_div ? STEP_DIV : STEP_MUL;

    muldiv_step u_step (
        .mode   (step_mode),
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .acc_o  (acc_step)
    );

    // Operand conditioning and final fixup, all from the latched operands.
    always_comb begin
        sign_a = op_signed_a(funct3_q) & a_q[31];
        sign_b = op_signed_b(funct3_q) & b_q[31];
        abs_a  = sign_a ? (~a_q + 32'd1) : a_q;
        abs_b  = sign_b ? (~b_q + 32'd1) : b_q;

        div_by_zero = is_div & (b_q == 32'd0);
        // Only DIV and REM (funct3[0]==0) are signed divides.
        div_ovf     = is_div & ~funct3_q[0] &
                      (a_q == 32'h8000_0000) & (b_q == 32'hFFFF_FFFF);

        // funct3[1] distinguishes REM/REMU from DIV/DIVU.
        special_val = 32'd0;
        if (div_by_zero) begin
            special_val = funct3_q[1] ? a_q : 32'hFFFF_FFFF;
        end else if (div_ovf) begin
            special_val = funct3_q[1] ? 32'd0 : 32'h8000_0000;
        end

        // The high word of a signed product needs the full 64-bit negation.
        prod_signed = neg_q ? (~acc_q + 64'd1) : acc_q;

        case (funct3_q)
            MULDIV_MUL:                     fix_val = prod_signed[31:0];
            MULDIV_MULH, MULDIV_MULHSU,
            MULDIV_MULHU:                   fix_val = prod_signed[63:32];
            MULDIV_DIV, MULDIV_DIVU:        fix_val = neg_q ? (~acc_q[31:0] + 32'd1)
                                                            : acc_q[31:0];
            default:                        fix_val = neg_q ? (~acc_q[63:32] + 32'd1)
                                                            : acc_q[63:32];
        endcase

        if (div_by_zero || div_ovf) begin
            fix_val = special_val;
        end
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic trivial;
    assign trivial = div_by_zero | div_ovf |
                     (~is_div & ((a_q == 32'd0) | (b_q == 32'd0)));
`endif

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        funct3_d = funct3_q;
        a_d      = a_q;
        b_d      = b_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        result_d = result_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !kill) begin
                    funct3_d = funct3;
                    a_d      = op_a;
                    b_d      = op_b;
                    state_d  = ST_PREP;
                end
            end
            ST_PREP: begin
                // Low half seeds the multiplier or the dividend; high half starts at 0.
                acc_d  = {32'd0, abs_a};
                opnd_d = abs_b;
                cnt_d  = 5'd0;
                // Remainder takes the dividend's sign; everything else the XOR.
                neg_d  = (is_div && funct3_q[1]) ? sign_a : (sign_a ^ sign_b);
                state_d = ST_CALC;
`ifdef MULDIV_EARLY_OUT_EN
                if (trivial) begin
                    result_d = special_val;
                    state_d  = ST_DONE;
                end
`endif
            end
            ST_CALC: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                result_d = fix_val;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Flush drops the operation; a done already on the wire still stands.
        if (kill && (state_q != ST_IDLE)) begin
            state_d  = ST_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            funct3_q <= 3'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            opnd_q   <= 32'd0;
            acc_q    <= 64'd0;
            cnt_q    <= 5'd0;
            neg_q    <= 1'b0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            funct3_q <= funct3_d;
            a_q      <= a_d;
            b_q      <= b_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        busy   = (state_q == ST_PREP) || (state_q == ST_CALC) || (state_q == ST_FIX);
        done   = (state_q == ST_DONE);
        result = result_q;
    end

endmodule
